// File: rtl/rst_pkg.sv
// ============================================================================
// Module      : rst_pkg
// Description : Shared constants and entry type for the register status table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_pkg;

    localparam int TAG_WIDTH     = 5;
    localparam int NUM_REGS      = 32;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [REG_IDX_WIDTH-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

endpackage : rst_pkg

`default_nettype wire

// File: rtl/rst_lookup.sv
// ============================================================================
// Module      : rst_lookup
// Description : One source-operand port: index decode, r0 override and the
//               optional same-cycle CDB bypass (macro RST_CDB_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_lookup
    import rst_pkg::*;
#(
    parameter int NUM_REGS  = rst_pkg::NUM_REGS,
    parameter int TAG_WIDTH = rst_pkg::TAG_WIDTH
) (
    input  logic [REG_IDX_WIDTH-1:0]              i_idx,
    input  logic [NUM_REGS-1:0]                   i_busy_vec,
    input  logic [NUM_REGS-1:0][TAG_WIDTH-1:0]    i_tag_vec,
    input  logic                                  i_cdb_valid,
    input  logic [TAG_WIDTH-1:0]                  i_cdb_tag,
    output logic                                  o_busy,
    output logic [TAG_WIDTH-1:0]                  o_tag
);

    logic                 w_busy;
    logic [TAG_WIDTH-1:0] w_tag;

`ifndef RST_CDB_BYPASS_EN
    logic w_unused_cdb;
    assign w_unused_cdb = ^{i_cdb_valid, i_cdb_tag};
`endif

    always_comb begin
        w_busy = 1'b0;
        w_tag  = '0;
        if ((i_idx != ZERO_REG) && (32'(i_idx) < NUM_REGS)) begin
            w_busy = i_busy_vec[i_idx];
            w_tag  = i_tag_vec[i_idx];
        end
`ifdef RST_CDB_BYPASS_EN
        // Producer is broadcasting right now: the operand is already available.
        if (w_busy && i_cdb_valid && (w_tag == i_cdb_tag)) begin
            w_busy = 1'b0;
        end
`endif
        o_busy = w_busy;
        o_tag  = w_busy ? w_tag : '0;
    end

endmodule : rst_lookup

`default_nettype wire

// File: rtl/register_status_table.sv
// ============================================================================
// Module      : register_status_table
// Description : Rename map for the OoO core; pops tags from the free-list FIFO,
//               tracks pending registers, clears them on CDB broadcast.
//               Optional same-cycle CDB bypass: RST_CDB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_status_table
    import rst_pkg::*;
#(
    parameter int NUM_REGS  = rst_pkg::NUM_REGS,
    parameter int TAG_WIDTH = rst_pkg::TAG_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush_valid,
    input  logic                      dispatch_valid,
    input  logic                      dispatch_wr,
    input  logic [REG_IDX_WIDTH-1:0]  dispatch_rd,
    input  logic [REG_IDX_WIDTH-1:0]  dispatch_rs,
    input  logic [REG_IDX_WIDTH-1:0]  dispatch_rt,
    output logic                      dispatch_ready,
    input  logic                      tag_fifo_empty,
    input  logic [TAG_WIDTH-1:0]      tag_out,
    output logic                      rd_en,
    output logic [TAG_WIDTH-1:0]      dispatch_tag,
    output logic                      rs_busy,
    output logic                      rt_busy,
    output logic [TAG_WIDTH-1:0]      rs_tag,
    output logic [TAG_WIDTH-1:0]      rt_tag,
    input  logic                      cdb_valid,
    input  logic [TAG_WIDTH-1:0]      cdb_tag
);

    logic                               w_need_tag;
    logic [NUM_REGS-1:0]                w_busy_vec;
    logic [NUM_REGS-1:0][TAG_WIDTH-1:0] w_tag_vec;

    assign w_need_tag     = dispatch_valid && dispatch_wr && (dispatch_rd != ZERO_REG);
    assign dispatch_ready = dispatch_valid && !flush_valid && !(w_need_tag && tag_fifo_empty);
    // The FIFO is reset by the same event, so never pop it while reset is held.
    assign rd_en          = dispatch_ready && w_need_tag && !reset;
    assign dispatch_tag   = tag_out;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign w_busy_vec[i] = 1'b0;
            assign w_tag_vec[i]  = '0;
        end else begin : g_reg
            logic                 r_busy;
            logic [TAG_WIDTH-1:0] r_tag;
            logic                 w_alloc;
            logic                 w_cdb_hit;

            assign w_alloc   = rd_en && (dispatch_rd == REG_IDX_WIDTH'(i));
            assign w_cdb_hit = cdb_valid && r_busy && (r_tag == cdb_tag);

            // Priority: flush, then a new allocation, then the CDB clear.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_busy <= 1'b0;
                    r_tag  <= '0;
                end else if (flush_valid) begin
                    r_busy <= 1'b0;
                end else if (w_alloc) begin
                    r_busy <= 1'b1;
                    r_tag  <= tag_out;
                end else if (w_cdb_hit) begin
                    r_busy <= 1'b0;
                end
            end

            assign w_busy_vec[i] = r_busy;
            assign w_tag_vec[i]  = r_tag;
        end
    end

    rst_lookup #(
        .NUM_REGS  (NUM_REGS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rs_lookup (
        .i_idx       (dispatch_rs),
        .i_busy_vec  (w_busy_vec),
        .i_tag_vec   (w_tag_vec),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .o_busy      (rs_busy),
        .o_tag       (rs_tag)
    );

    rst_lookup #(
        .NUM_REGS  (NUM_REGS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rt_lookup (
        .i_idx       (dispatch_rt),
        .i_busy_vec  (w_busy_vec),
        .i_tag_vec   (w_tag_vec),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .o_busy      (rt_busy),
        .o_tag       (rt_tag)
    );

endmodule : register_status_table

`default_nettype wire

// File: doc/register_status_table.md
# register_status_table

Register status table (rename map) for the out-of-order MIPS core. It sits directly downstream of the tag free-list FIFO. On dispatch it pops a free tag for the instruction's destination register and records the register as pending on that tag. It reports the pending/ready status of both source operands to the issue logic, and clears pending entries when the common data bus (CDB) broadcasts the matching tag.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never renamed.
- TAG_WIDTH, 5, tag width; must match the tag FIFO.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_valid  in  1  pipeline flush; clears all pending entries; shared with the tag FIFO.
- dispatch_valid  in  1  an instruction is presented for dispatch this cycle.
- dispatch_wr  in  1  the instruction writes a destination register.
- dispatch_rd  in  5  destination register index.
- dispatch_rs, dispatch_rt  in  5 each  source register indices.
- dispatch_ready  out  1  dispatch accepted this cycle.
- tag_fifo_empty  in  1  from the tag FIFO.
- tag_out  in  TAG_WIDTH  head tag of the tag FIFO.
- rd_en  out  1  pop strobe to the tag FIFO.
- dispatch_tag  out  TAG_WIDTH  tag assigned to the destination; equals tag_out.
- rs_busy, rt_busy  out  1 each  source operand is pending.
- rs_tag, rt_tag  out  TAG_WIDTH each  tag the pending source waits on; 0 when not busy.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.

## Operation
- State: one entry per register, each holding a busy bit and a TAG_WIDTH tag. Entry 0 is hard-wired not busy.
- Allocation condition `need_tag`: dispatch_valid && dispatch_wr && dispatch_rd != 0.
- dispatch_ready = dispatch_valid && !flush_valid && !(need_tag && tag_fifo_empty).
- rd_en = dispatch_ready && need_tag. The block never pops the FIFO when it is empty, and never pops it during a flush.
- On a clock edge with rd_en set: entry[dispatch_rd] becomes busy with tag tag_out.
- On a clock edge with cdb_valid set: every busy entry whose tag equals cdb_tag clears busy. The tag field is left unchanged.
- Same entry allocated and CDB-matched in the same cycle: the allocation wins and the entry ends busy with the new tag.
- Source lookup is combinational from current state. It reads entry[dispatch_rs] / entry[dispatch_rt]; register 0 always reads not busy.
- A source equal to dispatch_rd of the same instruction reads the old mapping, not the tag being allocated.
- flush_valid: all busy bits clear at the next edge. A flush overrides both allocation and CDB in that cycle.
- reset: all busy bits and tags go to 0 asynchronously. Reset asserted mid-dispatch drops the allocation; the tag FIFO is reset by the same event.

## Timing
- Lookup to rs_/rt_ outputs: zero-cycle combinational.
- Allocation is visible on lookups in the cycle after the rd_en edge.
- Without bypass, a CDB clear is visible in the cycle after the broadcast.
- rd_en, dispatch_ready and dispatch_tag are combinational from the inputs and state. There is no registered handshake.
- Output values while reset is asserted: rd_en=0; dispatch_ready=0 unless dispatch_valid; rs_/rt_busy=0; rs_/rt_tag=0.

## Configuration
- RST_CDB_BYPASS_EN defined: a source lookup that hits a busy entry whose tag equals cdb_tag while cdb_valid is set reports busy=0 and tag=0 in the same cycle.
- RST_CDB_BYPASS_EN undefined: lookups reflect registered state only, and the source reads busy during the broadcast cycle.
- The bypass never overrides an allocation for the same register in the same cycle.

## Structure
- Shared package `rst_pkg`:
  - TAG_WIDTH and NUM_REGS constants.
  - REG_IDX_WIDTH = 5.
  - Entry typedef (busy, tag).
  - ZERO_REG constant.
- One sub-module, `rst_lookup`, is instantiated twice (rs, rt). It holds the index decode, the zero-register override and the optional CDB bypass.

## Test plan
- Reset, then dispatch rd=3 with tag_out=0 and FIFO non-empty: rd_en=1, dispatch_ready=1. Next cycle, rs=3 gives rs_busy=1, rs_tag=0.
- Dispatch with rd=0 and dispatch_wr=1: rd_en=0, dispatch_ready=1, and no entry changes.
- tag_fifo_empty=1 with an allocating dispatch: dispatch_ready=0 and rd_en=0. A non-writing dispatch in the same state still gives dispatch_ready=1.
- Regs 5 and 7 busy on tags 4 and 9; cdb_valid with cdb_tag=4: reg 5 is not busy next cycle and reg 7 stays busy with tag 9.
- Reg 5 busy on tag 4; same cycle cdb_tag=4 and a dispatch with rd=5 and tag_out=12: reg 5 ends busy with tag 12. With RST_CDB_BYPASS_EN defined, rs=5 during the broadcast reads busy=0.
- Several regs busy, then flush_valid for one cycle together with an allocating dispatch: rd_en=0, and all entries read not busy next cycle. An async reset asserted mid-cycle gives the same result immediately.
